// File: rtl/sm_fifo_pkg.sv
// Shared definitions for the register FIFO: pointer sizing helper and
// the pointer/count type for the default configuration.
package sm_fifo_pkg;

    localparam int DEFAULT_SIZE  = 32;
    localparam int DEFAULT_DEPTH = 4;

    // One extra pointer bit separates "full" from "empty" when the low bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_PTR_W = ptr_w(DEFAULT_DEPTH);

    typedef logic [DEFAULT_PTR_W-1:0] ptr_t;

endpackage

// File: rtl/sm_fifo_mem.sv
// DEPTH x SIZE register storage with one synchronous write port and an
// asynchronous read port. Contents are deliberately not reset.
module sm_fifo_mem #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [SIZE-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [SIZE-1:0] rdata
);

    logic [SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sm_reg_fifo.sv
// Register-based synchronous FIFO, valid/ready on both sides, first-word-fall-through.
// Pointers carry one wrap bit so full and empty are both derived from pointer compare.
module sm_reg_fifo
    import sm_fifo_pkg::*;
#(
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [SIZE-1:0]            wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [SIZE-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sm_reg_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Both handshake outputs come from registered state only, so there is no
    // combinational path from rd_ready to wr_ready or from wr_* to rd_*.
    assign wr_ready = rst & ~full;
    assign rd_valid = ~empty;
    assign count    = wr_ptr_q - rd_ptr_q;

    assign push = wr_valid & wr_ready;
    assign pop  = rd_valid & rd_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    sm_fifo_mem #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_sm_reg_fifo.sv
// Directed self-checking bench for sm_reg_fifo (SIZE=32, DEPTH=4).
module tb_sm_reg_fifo;

    localparam int SIZE  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_valid;
    logic            wr_ready;
    logic [SIZE-1:0] wr_data;
    logic            rd_valid;
    logic            rd_ready;
    logic [SIZE-1:0] rd_data;
    logic [2:0]      count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sm_reg_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        step();
        step();
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
        rst = 1'b1;
        step();
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_wr_ready got=%b exp=1", wr_ready); end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL post_reset_count got=%0d exp=0", count); end
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL post_reset_rd_valid got=%b exp=0", rd_valid); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hA0 + i;
            step();
            checks++;
            if (count !== 3'(i + 1)) begin
                errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1);
            end
        end
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL fill_wr_ready_full got=%b exp=0", wr_ready); end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hA0) begin
            errors++; $display("FAIL fill_head got=%b/%h exp=1/000000a0", rd_valid, rd_data);
        end
        wr_data = 32'hA4;
        step();
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL fill_overflow_count got=%0d exp=4", count); end
        wr_valid = 1'b0;
    endtask

    task automatic test_drain();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 32'hA0 + i) begin
                errors++;
                $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, 32'hA0 + i);
            end
            step();
        end
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL drain_rd_valid got=%b exp=0", rd_valid); end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", count); end
        rd_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hB0 + i;
            step();
        end
        wr_data  = 32'hC0;
        rd_ready = 1'b1;
        checks++;
        if (wr_ready !== 1'b0 || count !== 3'd4) begin
            errors++; $display("FAIL fpp_full got=%b/%0d exp=0/4", wr_ready, count);
        end
        step();
        wr_valid = 1'b0;
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL fpp_count got=%0d exp=3", count); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 32'hB0 + i) begin
                errors++;
                $display("FAIL fpp_data[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, 32'hB0 + i);
            end
            step();
        end
        checks++;
        if (rd_valid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL fpp_c0_dropped got=%b/%0d exp=0/0", rd_valid, count);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_wrap_stream();
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        wr_data  = 32'd0;
        step();
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (count !== 3'd1 || rd_valid !== 1'b1 || rd_data !== 32'(k)) begin
                errors++;
                $display("FAIL wrap[%0d] got=%0d/%b/%h exp=1/1/%h", k, count, rd_valid, rd_data, 32'(k));
            end
            if (k < 19) wr_data = 32'(k + 1);
            else        wr_valid = 1'b0;
            step();
        end
        checks++;
        if (count !== 3'd0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_end got=%0d/%b exp=0/0", count, rd_valid);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hD0 + i;
            step();
        end
        checks++;
        if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
        rst      = 1'b0;
        wr_data  = 32'h77;
        rd_ready = 1'b1;
        step();
        checks++;
        if (count !== 3'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got=%0d/%b/%b exp=0/0/0", count, rd_valid, wr_ready);
        end
        rst      = 1'b1;
        rd_ready = 1'b0;
        wr_data  = 32'h55;
        step();
        wr_valid = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h55 || count !== 3'd1) begin
            errors++;
            $display("FAIL mid_push got=%b/%h/%0d exp=1/00000055/1", rd_valid, rd_data, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_push_pop();
        test_wrap_stream();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
